// File: rtl/singcyc_periph_pkg.sv
// Shared address map, TCON bit indices and peripheral decode for the single-cycle core's bus.
// PERIPH_TIMER_EN (see singcyc_periph_timer) does not change anything in this package.
package singcyc_periph_pkg;

  localparam logic [31:0] PERIPH_BASE  = 32'h4000_0000;
  localparam logic [31:0] ADDR_TH      = PERIPH_BASE + 32'h00;
  localparam logic [31:0] ADDR_TL      = PERIPH_BASE + 32'h04;
  localparam logic [31:0] ADDR_TCON    = PERIPH_BASE + 32'h08;
  localparam logic [31:0] ADDR_LED     = PERIPH_BASE + 32'h0C;
  localparam logic [31:0] ADDR_SWITCH  = PERIPH_BASE + 32'h10;
  localparam logic [31:0] ADDR_DIGIT   = PERIPH_BASE + 32'h14;
  localparam logic [31:0] ADDR_SYSTICK = PERIPH_BASE + 32'h18;

  localparam int unsigned TCON_EN = 0;
  localparam int unsigned TCON_IE = 1;
  localparam int unsigned TCON_IS = 2;

  typedef enum logic [2:0] {
    SelNone,
    SelTh,
    SelTl,
    SelTcon,
    SelLed,
    SelSwitch,
    SelDigit,
    SelSystick
  } periph_sel_e;

  // Byte lane bits are ignored: every register is word-addressed.
  function automatic periph_sel_e periph_decode(input logic [31:0] addr);
    logic [31:0] word_addr;
    word_addr = {addr[31:2], 2'b00};
    case (word_addr)
      ADDR_TH:      return SelTh;
      ADDR_TL:      return SelTl;
      ADDR_TCON:    return SelTcon;
      ADDR_LED:     return SelLed;
      ADDR_SWITCH:  return SelSwitch;
      ADDR_DIGIT:   return SelDigit;
      ADDR_SYSTICK: return SelSystick;
      default:      return SelNone;
    endcase
  endfunction

endpackage

// File: rtl/singcyc_periph_timer.sv
// Reload timer (TH/TL/TCON) with level interrupt. Compiled in only when PERIPH_TIMER_EN is
// defined; otherwise every output is tied to 0 and writes are dropped.
module singcyc_periph_timer
  import singcyc_periph_pkg::*;
(
  input  logic        iClk,
  input  logic        iRst_n,
  input  logic        iThWe,
  input  logic        iTlWe,
  input  logic        iTconWe,
  input  logic [31:0] iWrData,
  output logic [31:0] oTh,
  output logic [31:0] oTl,
  output logic [2:0]  oTcon,
  output logic        oIrq
);

`ifdef PERIPH_TIMER_EN
  logic [31:0] th_q, th_d;
  logic [31:0] tl_q, tl_d;
  logic [2:0]  tcon_q, tcon_d;
  logic        overflow;

  always_comb begin
    overflow = tcon_q[TCON_EN] && (tl_q == 32'hFFFF_FFFF);
    th_d     = iThWe ? iWrData : th_q;

    tl_d = tl_q;
    if (iTlWe) begin
      tl_d = iWrData;
    end else if (tcon_q[TCON_EN]) begin
      tl_d = overflow ? th_q : tl_q + 32'd1;
    end

    // A same-cycle software clear must not swallow a fresh overflow.
    tcon_d = iTconWe ? iWrData[2:0] : tcon_q;
    if (overflow && tcon_q[TCON_IE]) begin
      tcon_d[TCON_IS] = 1'b1;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      th_q   <= '0;
      tl_q   <= '0;
      tcon_q <= '0;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      tcon_q <= tcon_d;
    end
  end

  assign oTh   = th_q;
  assign oTl   = tl_q;
  assign oTcon = tcon_q;
  assign oIrq  = tcon_q[TCON_IS];
`else
  logic unused_timer_in;
  assign unused_timer_in = ^{iClk, iRst_n, iThWe, iTlWe, iTconWe, iWrData};

  assign oTh   = '0;
  assign oTl   = '0;
  assign oTcon = '0;
  assign oIrq  = 1'b0;
`endif

endmodule

// File: rtl/singcyc_periph_bus.sv
// Data-side bus for the single-cycle MIPS core: data RAM plus memory-mapped peripherals.
// Timer registers exist only when PERIPH_TIMER_EN is defined (see singcyc_periph_timer).
module singcyc_periph_bus
  import singcyc_periph_pkg::*;
#(
  parameter int unsigned DMEM_WORDS = 256
) (
  input  logic        iClk,
  input  logic        iRst_n,
  input  logic [31:0] iAddr,
  input  logic        iMemRead,
  input  logic        iMemWrite,
  input  logic [31:0] iWrData,
  output logic [31:0] oRdData,
  input  logic [7:0]  iSwitch,
  output logic [7:0]  oLed,
  output logic [11:0] oDigit,
  output logic        oIrq
);

  localparam int unsigned DmemAw = $clog2(DMEM_WORDS);

  logic              ram_sel;
  logic [DmemAw-1:0] ram_idx;
  periph_sel_e       sel;
  logic [31:0]       ram_q [DMEM_WORDS];

  logic [7:0]  led_q, led_d;
  logic [11:0] digit_q, digit_d;
  logic [31:0] systick_q, systick_d;
  logic [7:0]  sw_meta_q, sw_meta_d;
  logic [7:0]  sw_sync_q, sw_sync_d;

  logic [31:0] tmr_th, tmr_tl;
  logic [2:0]  tmr_tcon;

  assign ram_sel = (iAddr[31:DmemAw+2] == '0);
  assign ram_idx = iAddr[DmemAw+1:2];
  assign sel     = periph_decode(iAddr);

  logic unused_addr;
  assign unused_addr = ^iAddr[1:0];

  // RAM is deliberately left out of reset.
  always_ff @(posedge iClk) begin
    if (iMemWrite && ram_sel) begin
      ram_q[ram_idx] <= iWrData;
    end
  end

  always_comb begin
    led_d     = (iMemWrite && sel == SelLed)   ? iWrData[7:0]  : led_q;
    digit_d   = (iMemWrite && sel == SelDigit) ? iWrData[11:0] : digit_q;
    systick_d = systick_q + 32'd1;
    sw_meta_d = iSwitch;
    sw_sync_d = sw_meta_q;
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      led_q     <= '0;
      digit_q   <= '0;
      systick_q <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      led_q     <= led_d;
      digit_q   <= digit_d;
      systick_q <= systick_d;
      sw_meta_q <= sw_meta_d;
      sw_sync_q <= sw_sync_d;
    end
  end

  singcyc_periph_timer u_timer (
    .iClk    (iClk),
    .iRst_n  (iRst_n),
    .iThWe   (iMemWrite && sel == SelTh),
    .iTlWe   (iMemWrite && sel == SelTl),
    .iTconWe (iMemWrite && sel == SelTcon),
    .iWrData (iWrData),
    .oTh     (tmr_th),
    .oTl     (tmr_tl),
    .oTcon   (tmr_tcon),
    .oIrq    (oIrq)
  );

  // Combinational read path: always reflects pre-write state within the cycle.
  always_comb begin
    oRdData = '0;
    if (iMemRead) begin
      if (ram_sel) begin
        oRdData = ram_q[ram_idx];
      end else begin
        case (sel)
          SelTh:      oRdData = tmr_th;
          SelTl:      oRdData = tmr_tl;
          SelTcon:    oRdData = {29'b0, tmr_tcon};
          SelLed:     oRdData = {24'b0, led_q};
          SelSwitch:  oRdData = {24'b0, sw_sync_q};
          SelDigit:   oRdData = {20'b0, digit_q};
          SelSystick: oRdData = systick_q;
          default:    oRdData = '0;
        endcase
      end
    end
  end

  assign oLed   = led_q;
  assign oDigit = digit_q;

endmodule

// File: tb/tb_singcyc_periph_bus.sv
// Randomised bench for singcyc_periph_bus against a behavioural model of the address map.
// Timer checks are included only when PERIPH_TIMER_EN is defined for the build.
module tb_singcyc_periph_bus;

  localparam int unsigned DW = 256;
  localparam logic [31:0] A_TH = 32'h4000_0000, A_TL = 32'h4000_0004, A_TCON = 32'h4000_0008;
  localparam logic [31:0] A_LED = 32'h4000_000C, A_SW = 32'h4000_0010, A_DIG = 32'h4000_0014;
  localparam logic [31:0] A_TICK = 32'h4000_0018;

  logic        iClk, iRst_n, iMemRead, iMemWrite, oIrq;
  logic [31:0] iAddr, iWrData, oRdData;
  logic [7:0]  iSwitch, oLed;
  logic [11:0] oDigit;

  singcyc_periph_bus #(.DMEM_WORDS(DW)) dut (
    .iClk      (iClk),
    .iRst_n    (iRst_n),
    .iAddr     (iAddr),
    .iMemRead  (iMemRead),
    .iMemWrite (iMemWrite),
    .iWrData   (iWrData),
    .oRdData   (oRdData),
    .iSwitch   (iSwitch),
    .oLed      (oLed),
    .oDigit    (oDigit),
    .oIrq      (oIrq)
  );

  initial begin
    iClk = 1'b0;
    forever #5 iClk = ~iClk;
  end

  // Reference model state
  logic [31:0] m_ram [DW];
  bit          m_ram_ok [DW];
  logic [7:0]  m_led;
  logic [11:0] m_digit;
  logic [31:0] m_tick;
  logic [7:0]  m_sw_q [$];
  logic [31:0] m_th, m_tl;
  logic [2:0]  m_tcon;

  int n_chk, n_pass;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic m_reset();
    m_led = '0; m_digit = '0; m_tick = '0;
    m_sw_q = {8'h00, 8'h00};
    m_th = '0; m_tl = '0; m_tcon = '0;
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a, output bit known);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    known = 1'b1;
    m_read = '0;
    if (a < 32'(DW * 4)) begin
      known  = m_ram_ok[int'(a >> 2)];
      m_read = m_ram[int'(a >> 2)];
    end else if (wa == A_LED) m_read = {24'b0, m_led};
    else if (wa == A_SW) m_read = {24'b0, m_sw_q[0]};
    else if (wa == A_DIG) m_read = {20'b0, m_digit};
    else if (wa == A_TICK) m_read = m_tick;
`ifdef PERIPH_TIMER_EN
    else if (wa == A_TH) m_read = m_th;
    else if (wa == A_TL) m_read = m_tl;
    else if (wa == A_TCON) m_read = {29'b0, m_tcon};
`endif
  endfunction

  task automatic m_edge(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [7:0] sw);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    if (wr && a < 32'(DW * 4)) begin
      m_ram[int'(a >> 2)]    = wd;
      m_ram_ok[int'(a >> 2)] = 1'b1;
    end
    if (wr && wa == A_LED) m_led = wd[7:0];
    if (wr && wa == A_DIG) m_digit = wd[11:0];
    m_tick = m_tick + 1;
    m_sw_q.push_back(sw);
    void'(m_sw_q.pop_front());
`ifdef PERIPH_TIMER_EN
    begin
      bit ovf;
      logic [31:0] n_tl;
      logic [2:0] n_tcon;
      ovf  = m_tcon[0] && (m_tl == 32'hFFFF_FFFF);
      n_tl = m_tcon[0] ? (ovf ? m_th : m_tl + 1) : m_tl;
      if (wr && wa == A_TL) n_tl = wd;
      n_tcon = (wr && wa == A_TCON) ? wd[2:0] : m_tcon;
      if (ovf && m_tcon[1]) n_tcon[2] = 1'b1;
      if (wr && wa == A_TH) m_th = wd;
      m_tl = n_tl;
      m_tcon = n_tcon;
    end
`endif
  endtask

  // One bus cycle: drive just after posedge, check at negedge, advance model at posedge.
  task automatic cyc(input logic rd, input logic wr, input logic [31:0] a,
                     input logic [31:0] wd, input logic [7:0] sw, output logic [31:0] rdo);
    logic [31:0] exp;
    bit known;
    iMemRead = rd; iMemWrite = wr; iAddr = a; iWrData = wd; iSwitch = sw;
    @(negedge iClk);
    known = 1'b1;
    exp = rd ? m_read(a, known) : 32'h0;
    if (known) check($sformatf("rd@%h", a), oRdData, exp);
    check("led", {24'b0, oLed}, {24'b0, m_led});
    check("digit", {20'b0, oDigit}, {20'b0, m_digit});
`ifdef PERIPH_TIMER_EN
    check("irq", {31'b0, oIrq}, {31'b0, m_tcon[2]});
`else
    check("irq", {31'b0, oIrq}, 32'h0);
`endif
    rdo = oRdData;
    @(posedge iClk);
    m_edge(wr, a, wd, sw);
    #1;
  endtask

  logic [31:0] r, t1, t2;
  logic [7:0]  sw_now;
  logic [31:0] raddr [7];

  initial begin
    n_chk = 0; n_pass = 0;
    for (int i = 0; i < int'(DW); i++) m_ram_ok[i] = 1'b0;
    iRst_n = 1'b0; iMemRead = 1'b0; iMemWrite = 1'b0; iAddr = '0; iWrData = '0; iSwitch = '0;
    m_reset();
    #1;
    check("rst_rd", oRdData, 32'h0);
    check("rst_led", {24'b0, oLed}, 32'h0);
    check("rst_digit", {20'b0, oDigit}, 32'h0);
    check("rst_irq", {31'b0, oIrq}, 32'h0);
    #15 iRst_n = 1'b1;

    // Every mapped register reads 0 after reset; SYSTICK first so it has not yet counted.
    raddr = '{A_TICK, A_TH, A_TL, A_TCON, A_LED, A_SW, A_DIG};
    for (int i = 0; i < 7; i++) begin
      cyc(1'b1, 1'b0, raddr[i], 32'h0, 8'h00, r);
      check($sformatf("rst_map%0d", i), r, 32'h0);
    end

    cyc(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 8'h00, r);
    cyc(1'b1, 1'b0, 32'h0000_0010, 32'h0, 8'h00, r);
    check("ram_10", r, 32'hDEAD_BEEF);
    cyc(1'b1, 1'b0, 32'h0000_0013, 32'h0, 8'h00, r);
    check("ram_13", r, 32'hDEAD_BEEF);
    cyc(1'b1, 1'b0, 32'h0000_2000, 32'h0, 8'h00, r);
    check("ram_oor", r, 32'h0);
    cyc(1'b1, 1'b1, 32'h0000_0010, 32'h1111_2222, 8'h00, r);
    check("rd_pre_wr", r, 32'hDEAD_BEEF);

`ifdef PERIPH_TIMER_EN
    cyc(1'b0, 1'b1, A_TH, 32'hFFFF_FFFC, 8'h00, r);
    cyc(1'b0, 1'b1, A_TL, 32'hFFFF_FFFE, 8'h00, r);
    cyc(1'b0, 1'b1, A_TCON, 32'h3, 8'h00, r);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 8'h00, r);
    check("irq_early", {31'b0, oIrq}, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 8'h00, r);
    cyc(1'b1, 1'b0, A_TL, 32'h0, 8'h00, r);
    check("tl_reload", r, 32'hFFFF_FFFC);
    check("irq_2cyc", {31'b0, oIrq}, 32'h1);
    cyc(1'b0, 1'b1, A_TCON, 32'h3, 8'h00, r);
    check("irq_clr", {31'b0, oIrq}, 32'h0);
    cyc(1'b0, 1'b1, A_TL, 32'hFFFF_FFFF, 8'h00, r);
    cyc(1'b0, 1'b1, A_TCON, 32'h3, 8'h00, r);
    cyc(1'b1, 1'b0, A_TCON, 32'h0, 8'h00, r);
    check("tcon_race", r, 32'h7);
    check("irq_race", {31'b0, oIrq}, 32'h1);
`else
    cyc(1'b0, 1'b1, A_TCON, 32'h3, 8'h00, r);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 32'h0, 32'h0, 8'h00, r);
    cyc(1'b1, 1'b0, A_TCON, 32'h0, 8'h00, r);
    check("tcon_off", r, 32'h0);
    check("irq_off", {31'b0, oIrq}, 32'h0);
`endif

    cyc(1'b1, 1'b0, A_SW, 32'h0, 8'hA5, r);
    check("sw_0", r, 32'h0);
    cyc(1'b1, 1'b0, A_SW, 32'h0, 8'hA5, r);
    check("sw_1", r, 32'h0);
    cyc(1'b1, 1'b0, A_SW, 32'h0, 8'hA5, r);
    check("sw_2", r, 32'h0000_00A5);
    cyc(1'b0, 1'b1, A_LED, 32'h0000_1234, 8'hA5, r);
    check("led_34", {24'b0, oLed}, 32'h34);

    cyc(1'b1, 1'b0, A_TICK, 32'h0, 8'hA5, t1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 32'h0, 32'h0, 8'hA5, r);
    cyc(1'b1, 1'b0, A_TICK, 32'h0, 8'hA5, t2);
    check("tick_diff", t2 - t1, 32'd5);

    // Asynchronous reset in the middle of a cycle
    cyc(1'b0, 1'b1, A_DIG, 32'h0000_0ABC, 8'hA5, r);
    iMemWrite = 1'b0; iMemRead = 1'b0;
    #2 iRst_n = 1'b0;
    #1;
    check("arst_led", {24'b0, oLed}, 32'h0);
    check("arst_digit", {20'b0, oDigit}, 32'h0);
    check("arst_irq", {31'b0, oIrq}, 32'h0);
    @(posedge iClk);
    #1 iRst_n = 1'b1;
    iSwitch = 8'h00;
    m_reset();

    sw_now = 8'h00;
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      logic rd, wr;
      case ($urandom_range(0, 5))
        0, 1:    a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
        2:       a = A_TH + 32'($urandom_range(0, 8) * 4) + 32'($urandom_range(0, 3));
        3:       a = $urandom;
        4:       a = 32'($urandom_range(0, DW * 4 - 1));
        default: a = 32'h4000_0000 + 32'($urandom_range(0, 255));
      endcase
      rd = 1'($urandom_range(0, 1));
      wr = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) sw_now = 8'($urandom);
      cyc(rd, wr, a, $urandom, sw_now, r);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/singcyc_periph_bus.md
# singcyc_periph_bus

Memory-side bus unit that sits directly downstream of the single-cycle MIPS core's data port. Decodes the core's data address, read strobe and write strobe into an internal word-addressed data RAM and a small memory-mapped peripheral set: reload timer with interrupt, LEDs, switches, 7-segment drive and a free-running tick counter. Reads return combinationally in the same cycle, as the single-cycle datapath requires. Writes commit on the clock edge.

## Interface
- DMEM_WORDS, 256, data RAM depth in 32-bit words; power of two.
- iClk  in  1  core clock.
- iRst_n  in  1  reset, asynchronous, active-low.
- iAddr  in  32  byte address from the core's ALU result.
- iMemRead  in  1  read strobe.
- iMemWrite  in  1  write strobe.
- iWrData  in  32  store data.
- oRdData  out  32  load data, combinational.
- iSwitch  in  8  board switches, sampled through 2-flop synchroniser.
- oLed  out  8  LED register.
- oDigit  out  12  7-seg drive: [11:8] anode enables, [7:0] segments.
- oIrq  out  1  timer interrupt request, level.

## Operation
Address map uses iAddr[31:2]; iAddr[1:0] are ignored.
- 0x0000_0000 .. DMEM_WORDS*4-1: data RAM. Read is asynchronous; write is synchronous. RAM is not reset.
- 0x4000_0000 TH: reload value, R/W.
- 0x4000_0004 TL: counter, R/W.
- 0x4000_0008 TCON: R/W, [0] enable, [1] irq enable, [2] irq status; [31:3] read as 0.
- 0x4000_000C LED: R/W; low 8 bits are stored.
- 0x4000_0010 SWITCH: read-only, returns {24'b0, synchronised switches}.
- 0x4000_0014 DIGIT: R/W; low 12 bits are stored.
- 0x4000_0018 SYSTICK: read-only.
- Any other address reads 0; writes to it are ignored. Writes to read-only registers are ignored.

oRdData rules:
- oRdData = 0 whenever iMemRead = 0.
- If iMemRead and iMemWrite are both 1, the read returns the pre-write value.

Timer:
- While TCON[0] = 1, TL increments by 1 every cycle.
- When TL = 32'hFFFF_FFFF, the next TL is TH, not 0. On that same edge, TCON[2] sets if TCON[1] = 1.
- oIrq = TCON[2]. It clears only when software writes TCON with bit2 = 0.

Simultaneous events:
- CPU write to TL and a timer increment or reload in the same cycle: the CPU write wins.
- CPU write to TCON with bit2 = 0 and an overflow in the same cycle: status ends at 1, so no interrupt is lost. Bits [1:0] still take the written value.

SYSTICK: 32-bit counter, +1 every cycle, wraps to 0. Not writable.

## Timing
- Reset values: TH = 0, TL = 0, TCON = 0, LED = 0, DIGIT = 0, SYSTICK = 0, synchroniser = 0.
- Output reset values: oLed = 0, oDigit = 0, oIrq = 0, oRdData = 0.
- Read latency 0: oRdData is valid in the same cycle as iAddr and iMemRead.
- Write latency 1: the register is updated at the posedge where iMemWrite = 1, and is visible to reads in the next cycle.
- Switch path: a value change appears in the SWITCH read after 2 cycles.
- Timer period with TH = N, from reload to reload: 2^32 - N cycles.
- Asserting reset mid-count returns all registers to their reset values immediately; oIrq drops asynchronously.

## Configuration
PERIPH_TIMER_EN:
- Defined: TH/TL/TCON and the interrupt logic are compiled in.
- Undefined: TH/TL/TCON read 0, their writes are ignored, and oIrq is tied to 0. RAM, LED, SWITCH, DIGIT and SYSTICK are unaffected.

## Structure
- Package singcyc_periph_pkg holds:
  - address constants: PERIPH_BASE, ADDR_TH, ADDR_TL, ADDR_TCON, ADDR_LED, ADDR_SWITCH, ADDR_DIGIT, ADDR_SYSTICK;
  - TCON bit indices: TCON_EN = 0, TCON_IE = 1, TCON_IS = 2.
- Sub-module singcyc_periph_timer holds TH, TL and TCON. It takes write enables and data from the bus decode, and exposes its register values plus oIrq.
- The top level holds the decode, read mux, RAM, LED, DIGIT, SYSTICK and the synchroniser.

## Test plan
- Reset, then read every mapped address -> every read is 0; oLed = 0, oDigit = 0, oIrq = 0.
- Write 0xDEADBEEF to 0x0000_0010, then read 0x0000_0010 and 0x0000_0013 -> both read 0xDEADBEEF. Read 0x0000_2000 (DMEM_WORDS = 256) -> 0.
- Write TH = 0xFFFF_FFFC, TL = 0xFFFF_FFFE, then TCON = 3:
  - oIrq = 1 two cycles after the TCON write.
  - TL reads 0xFFFF_FFFC after the reload.
  - Write TCON = 3 -> oIrq = 0 in the next cycle.
- Write TCON = 3 (bit2 = 0) in the same cycle as an overflow -> TCON reads 7 and oIrq stays 1.
- Set iSwitch = 0xA5 -> a SWITCH read gives 0x0000_00A5 two cycles later. Write LED = 0x1234 -> oLed = 0x34.
- Build without PERIPH_TIMER_EN, write TCON = 3 and wait 10 cycles -> TCON reads 0 and oIrq stays 0. Two SYSTICK reads 5 cycles apart differ by 5.
